// File: rtl/memory_interface.sv
// memory_interface: single-access bridge between the multicycle control unit
// and the unified instruction/data memory.
//   clock, reset_n       : rising-edge clock, async active-low reset
//   access_start         : one-cycle start (ignored unless idle)
//   ir_write/memory_write: command (fetch / store / load; both = illegal)
//   address_source       : 0 -> pc, 1 -> result
//   pc, result, write_data
//   busy, done, fault    : status; done/fault pulse for one cycle
//   instruction, old_pc, data and decoded instruction fields
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : req/ack bus
module memory_interface #(
  parameter int          XLEN            = 32,
  parameter int          TIMEOUT_CYCLES  = 16,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            access_start,
  input  logic            ir_write,
  input  logic            memory_write,
  input  logic            address_source,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] write_data,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] data,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUS, COMPLETE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tcount;
  logic            we_r, fetch_r, fault_r;
  logic [XLEN-1:0] start_addr;
  logic            start_fault, timeout_hit;

  assign start_addr  = address_source ? result : pc;
  assign start_fault = (ir_write & memory_write) | (|start_addr[1:0]);
  // Last permitted wait cycle: an ack here still wins over the timeout.
  assign timeout_hit = (state == BUS) && !mem_ack &&
                       (tcount == TW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; faulting starts skip the bus entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (access_start) state_nxt = start_fault ? COMPLETE : BUS;
      BUS:      if (mem_ack || timeout_hit) state_nxt = COMPLETE;
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state == BUS);
    mem_req = (state == BUS);
    mem_we  = (state == BUS) && we_r;
    done    = (state == COMPLETE);
    fault   = (state == COMPLETE) && fault_r;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcount      <= '0;
      we_r        <= 1'b0;
      fetch_r     <= 1'b0;
      fault_r     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      old_pc      <= '0;
      data        <= '0;
      instruction <= NOP_INSTRUCTION;
    end else begin
      case (state)
        IDLE: if (access_start) begin
          fault_r <= start_fault;
          if (!start_fault) begin
            mem_addr <= start_addr;
            we_r     <= memory_write;
            fetch_r  <= ir_write;
            tcount   <= '0;
            if (memory_write) mem_wdata <= write_data;
            if (ir_write)     old_pc    <= pc;
          end
        end
        BUS: begin
          if (mem_ack) begin
            if (fetch_r)    instruction <= mem_rdata;
            else if (!we_r) data        <= mem_rdata;
          end else begin
            tcount <= tcount + TW'(1);
            if (timeout_hit) fault_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface: directed scenarios plus random
// accesses, compared against a transaction-level model of the access rules.
module tb_memory_interface;
  localparam int TO = 16;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        access_start = 0, ir_write = 0, memory_write = 0, address_source = 0;
  logic [31:0] pc = 0, result = 0, write_data = 0;
  logic        busy, done, fault, mem_req, mem_we, mem_ack = 0;
  logic [31:0] instruction, old_pc, data, mem_addr, mem_wdata, mem_rdata = 0;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int checks = 0, errors = 0;
  logic [31:0] exp_instr = NOP, exp_data = 0, exp_old_pc = 0;

  memory_interface #(.XLEN(32), .TIMEOUT_CYCLES(TO), .NOP_INSTRUCTION(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .access_start(access_start),
    .ir_write(ir_write), .memory_write(memory_write), .address_source(address_source),
    .pc(pc), .result(result), .write_data(write_data),
    .busy(busy), .done(done), .fault(fault),
    .instruction(instruction), .old_pc(old_pc), .data(data),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic check_regs(input string tag);
    checks++;
    if (instruction !== exp_instr || data !== exp_data || old_pc !== exp_old_pc) begin
      errors++;
      $display("FAIL %s regs: instr=%h data=%h old_pc=%h, expected %h %h %h",
               tag, instruction, data, old_pc, exp_instr, exp_data, exp_old_pc);
    end
    checks++;
    if (opcode !== exp_instr[6:0] || rd !== exp_instr[11:7] || funct3 !== exp_instr[14:12] ||
        rs1 !== exp_instr[19:15] || rs2 !== exp_instr[24:20] || funct7 !== exp_instr[31:25]) begin
      errors++;
      $display("FAIL %s fields: op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h, instr model %h",
               tag, opcode, rd, funct3, rs1, rs2, funct7, exp_instr);
    end
  endtask

  // One access with a bus responder that acks on req cycle wait_n+1.
  task automatic do_access(input bit ir, input bit mw, input bit asrc,
                           input logic [31:0] pcv, input logic [31:0] resv,
                           input logic [31:0] wd, input logic [31:0] rdv,
                           input int wait_n, input bit spurious, input string tag);
    logic [31:0] addr;
    bit cmd_fault, exp_fault, bad_bus, fault_seen, busy_at_done, extra_done;
    int exp_req, exp_done, reqs, done_cyc;
    addr      = asrc ? resv : pcv;
    cmd_fault = (ir && mw) || (addr[1:0] != 2'b00);
    exp_fault = cmd_fault || (wait_n >= TO);
    exp_req   = cmd_fault ? 0 : ((wait_n + 1 < TO) ? wait_n + 1 : TO);
    exp_done  = exp_req + 1;
    reqs = 0; done_cyc = -1; bad_bus = 0; fault_seen = 0; busy_at_done = 0; extra_done = 0;

    ir_write = ir; memory_write = mw; address_source = asrc;
    pc = pcv; result = resv; write_data = wd; access_start = 1;
    tick();
    access_start = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      if (spurious && k == 2) begin
        access_start = 1; ir_write = 1; memory_write = 0; address_source = 0;
        pc = pcv ^ 32'h0000_0100;
      end else access_start = 0;
      if (done) begin
        done_cyc = k; fault_seen = fault; busy_at_done = busy;
        break;
      end
      if (mem_req) begin
        reqs++;
        if (mem_addr !== addr || mem_we !== mw || (mw && mem_wdata !== wd) || busy !== 1'b1)
          bad_bus = 1;
        mem_ack   = (reqs == wait_n + 1);
        mem_rdata = mem_ack ? rdv : $urandom;
      end else mem_ack = 0;
      tick();
    end
    mem_ack = 0; access_start = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (done) extra_done = 1;
    end

    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, exp_done);
    end
    checks++;
    if (fault_seen != exp_fault) begin
      errors++; $display("FAIL %s fault: got %0b expected %0b", tag, fault_seen, exp_fault);
    end
    checks++;
    if (reqs != exp_req) begin
      errors++; $display("FAIL %s req_cycles: got %0d expected %0d", tag, reqs, exp_req);
    end
    checks++;
    if (bad_bus || busy_at_done || extra_done) begin
      errors++;
      $display("FAIL %s bus_status: unstable_bus=%0b busy_at_done=%0b extra_done=%0b expected 0 0 0",
               tag, bad_bus, busy_at_done, extra_done);
    end

    if (!cmd_fault) begin
      if (ir) exp_old_pc = pcv;
      if (!exp_fault) begin
        if (ir) exp_instr = rdv;
        else if (!mw) exp_data = rdv;
      end
    end
    check_regs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (busy !== 0 || done !== 0 || fault !== 0 || mem_req !== 0 || mem_we !== 0 ||
        mem_addr !== 0 || mem_wdata !== 0 || old_pc !== 0 || data !== 0 ||
        instruction !== NOP || opcode !== 7'h13) begin
      errors++;
      $display("FAIL %s reset_state: busy=%b done=%b fault=%b req=%b we=%b addr=%h wdata=%h old_pc=%h data=%h instr=%h op=%h",
               tag, busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata, old_pc, data, instruction, opcode);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    check_reset_state("reset");
    reset_n = 1;
    tick();
    exp_instr = NOP; exp_data = 0; exp_old_pc = 0;
    check_regs("reset");
  endtask

  task automatic test_fetch();
    do_access(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h00A00093, 0, 0, "fetch");
    checks++;
    if (rd !== 5'd1 || opcode !== 7'h13 || old_pc !== 32'h40) begin
      errors++; $display("FAIL fetch_decode: rd=%0d op=%h old_pc=%h expected 1 13 40", rd, opcode, old_pc);
    end
  endtask

  task automatic test_load_wait();
    do_access(0, 0, 1, 32'h44, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, "load_wait3");
  endtask

  task automatic test_store();
    do_access(0, 1, 1, 32'h44, 32'h200, 32'h12345678, 32'hCAFEF00D, 1, 0, "store");
  endtask

  task automatic test_faults();
    do_access(0, 0, 1, 32'h44, 32'h102, 32'h0, 32'h11111111, 0, 0, "misaligned");
    do_access(1, 1, 0, 32'h48, 32'h0, 32'h0, 32'h22222222, 0, 0, "illegal_cmd");
  endtask

  task automatic test_timeout_busy();
    do_access(1, 0, 0, 32'h80, 32'h0, 32'h0, 32'h33333333, TO, 1, "timeout_busy");
    do_access(1, 0, 0, 32'h84, 32'h0, 32'h0, 32'h00B00113, TO - 1, 0, "last_wait_ack");
  endtask

  task automatic test_idle_ack();
    bit saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1; mem_rdata = $urandom;
      tick();
      if (done || mem_req) saw_done = 1;
    end
    mem_ack = 0;
    tick();
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL idle_ack: got activity=1 expected 0");
    end
    check_regs("idle_ack");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit ir, mw, asrc, sp;
      logic [31:0] pcv, resv;
      int w;
      ir = $urandom_range(0, 1); mw = $urandom_range(0, 1);
      if (ir && mw && $urandom_range(0, 3) != 0) mw = 0;
      asrc = $urandom_range(0, 1);
      pcv  = $urandom & 32'hFFFF_FFFC;
      resv = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) begin
        pcv[1:0] = 2'($urandom_range(1, 3)); resv[1:0] = 2'($urandom_range(1, 3));
      end
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 5);
      sp = (w >= 2) && ($urandom_range(0, 1) == 1);
      do_access(ir, mw, asrc, pcv, resv, $urandom, $urandom, w, sp, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    ir_write = 0; memory_write = 0; address_source = 1; result = 32'h300; access_start = 1;
    tick();
    access_start = 0;
    tick();
    reset_n = 0;
    #1;
    check_reset_state("reset_mid");
    tick();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || mem_req) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL reset_mid_activity: got 1 expected 0");
    end
    exp_instr = NOP; exp_data = 0; exp_old_pc = 0;
    check_regs("reset_mid");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_wait();
    test_store();
    test_faults();
    test_timeout_busy();
    test_idle_ack();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
